// File: rtl/multi_dataflow_job_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_dataflow_job_sequencer_if
//  Purpose  : Handshake bundle between the job sequencer and the dataflow
//             engine it drives.
//  Signals  : eng_ready_i  engine ready flag               (engine -> seq)
//             eng_cnt_i    engine output-handshake count   (engine -> seq)
//             eng_start_o  engine start pulse              (seq -> engine)
//             eng_clear_o  engine clear pulse              (seq -> engine)
//             Suffixes are written from the sequencer's point of view.
//  Modports : master = sequencer side, slave = engine side
//  Revision : 1.0  initial release
// ============================================================================
interface multi_dataflow_job_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             eng_ready_i;
    logic [CNT_W-1:0] eng_cnt_i;
    logic             eng_start_o;
    logic             eng_clear_o;

    modport master (
        input  eng_ready_i,
        input  eng_cnt_i,
        output eng_start_o,
        output eng_clear_o
    );

    modport slave (
        output eng_ready_i,
        output eng_cnt_i,
        input  eng_start_o,
        input  eng_clear_o
    );
endinterface
`default_nettype wire

// File: rtl/multi_dataflow_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_dataflow_job_sequencer
//  Purpose  : Runs one dataflow-engine job per trigger: clear the engine,
//             wait for ready, start it, wait for the expected output count,
//             then report done / error with a status code and a job counter.
//  Ports    : clk_i          clock (rising edge)
//             rst_ni         asynchronous active-low reset
//             trigger_i      job request pulse (accepted only when idle)
//             clear_i        synchronous abort / clear request
//             cfg_len_i      expected engine outputs per job
//             cfg_timeout_i  cycle budget per wait phase, 0 = no timeout
//             eng            engine handshake bundle (master modport)
//             busy_o         high whenever not idle
//             evt_done_o     one-cycle job-complete event
//             evt_err_o      one-cycle job-error event
//             status_o       00 none, 01 ok, 10 timeout, 11 zero length
//             jobs_o         completed-job count (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module multi_dataflow_job_sequencer #(
    parameter int CNT_W = 32,
    parameter int JOB_W = 16
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic                  trigger_i,
    input  wire logic                  clear_i,
    input  wire logic [CNT_W-1:0]      cfg_len_i,
    input  wire logic [CNT_W-1:0]      cfg_timeout_i,
    multi_dataflow_job_sequencer_if.master eng,
    output logic                       busy_o,
    output logic                       evt_done_o,
    output logic                       evt_err_o,
    output logic [1:0]                 status_o,
    output logic [JOB_W-1:0]           jobs_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_WAIT_READY = 3'd2,
        S_START      = 3'd3,
        S_RUN        = 3'd4,
        S_DONE       = 3'd5,
        S_ERR        = 3'd6
    } state_e;

    localparam logic [1:0] c_ST_NONE    = 2'b00;
    localparam logic [1:0] c_ST_OK      = 2'b01;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b10;
    localparam logic [1:0] c_ST_ZERO    = 2'b11;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] tmo_cfg_q, tmo_cfg_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]       status_q, status_d;
    logic [JOB_W-1:0] jobs_q, jobs_d;
    // One-cycle flag that produces the engine clear pulse after an abort.
    logic             abort_q, abort_d;

    logic [CNT_W-1:0] w_tmo_next;
    logic             w_tmo_hit;
    logic             w_wait_state;

    // The counter holds the number of completed cycles in the current wait
    // state, so the budget expires at the end of the cycle that brings the
    // count up to the configured timeout (timeout N = N cycles in the state).
    assign w_tmo_next   = tmo_cnt_q + CNT_W'(1);
    assign w_tmo_hit    = (tmo_cfg_q != '0) && (w_tmo_next == tmo_cfg_q);
    assign w_wait_state = (state_q == S_WAIT_READY) || (state_q == S_RUN);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        tmo_cfg_d = tmo_cfg_q;
        status_d  = status_q;
        jobs_d    = jobs_q;
        abort_d   = 1'b0;

        if (clear_i) begin
            // Abort dominates everything, including a simultaneous trigger.
            state_d  = S_IDLE;
            status_d = c_ST_NONE;
            abort_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (trigger_i) begin
                        len_d     = cfg_len_i;
                        tmo_cfg_d = cfg_timeout_i;
                        if (cfg_len_i == '0) begin
                            state_d  = S_ERR;
                            status_d = c_ST_ZERO;
                        end else begin
                            state_d  = S_CLEAR;
                            status_d = c_ST_NONE;
                        end
                    end
                end
                S_CLEAR: state_d = S_WAIT_READY;
                S_WAIT_READY: begin
                    // Exit condition is tested first so it wins a tie.
                    if (eng.eng_ready_i) begin
                        state_d = S_START;
                    end else if (w_tmo_hit) begin
                        state_d  = S_ERR;
                        status_d = c_ST_TIMEOUT;
                    end
                end
                S_START: state_d = S_RUN;
                S_RUN: begin
                    if (eng.eng_cnt_i >= len_q) begin
                        state_d  = S_DONE;
                        status_d = c_ST_OK;
                        jobs_d   = jobs_q + JOB_W'(1);
                    end else if (w_tmo_hit) begin
                        state_d  = S_ERR;
                        status_d = c_ST_TIMEOUT;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Any state change restarts the budget; staying in a wait state counts.
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (w_wait_state) begin
            tmo_cnt_d = w_tmo_next;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            tmo_cfg_q <= '0;
            tmo_cnt_q <= '0;
            status_q  <= c_ST_NONE;
            jobs_q    <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            tmo_cfg_q <= tmo_cfg_d;
            tmo_cnt_q <= tmo_cnt_d;
            status_q  <= status_d;
            jobs_q    <= jobs_d;
            abort_q   <= abort_d;
        end
    end

    // Moore outputs; the abort clear pulse only ever occurs in IDLE, so it
    // can never overlap the START pulse.
    assign eng.eng_clear_o = (state_q == S_CLEAR) || abort_q;
    assign eng.eng_start_o = (state_q == S_START);
    assign busy_o          = (state_q != S_IDLE);
    assign evt_done_o      = (state_q == S_DONE);
    assign evt_err_o       = (state_q == S_ERR);
    assign status_o        = status_q;
    assign jobs_o          = jobs_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_dataflow_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_dataflow_job_sequencer
//  Purpose  : Self-checking bench for multi_dataflow_job_sequencer. Each job
//             is described by (length, timeout, ready delay, count delay) and
//             a job-level model derives the expected cycle-by-cycle phase,
//             status code and job count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_dataflow_job_sequencer;

    localparam int CNT_W   = 16;
    localparam int JOB_W   = 2;
    localparam int JOB_MOD = 4;

    // Expected phase labels used by the job model.
    localparam int PH_IDLE  = 0;
    localparam int PH_CLR   = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_START = 3;
    localparam int PH_RUN   = 4;
    localparam int PH_DONE  = 5;
    localparam int PH_ERR   = 6;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             trigger_i = 1'b0;
    logic             clear_i = 1'b0;
    logic [CNT_W-1:0] cfg_len_i = '0;
    logic [CNT_W-1:0] cfg_timeout_i = '0;
    logic             busy_o;
    logic             evt_done_o;
    logic             evt_err_o;
    logic [1:0]       status_o;
    logic [JOB_W-1:0] jobs_o;

    multi_dataflow_job_sequencer_if #(.CNT_W(CNT_W)) eng_if ();

    multi_dataflow_job_sequencer #(
        .CNT_W (CNT_W),
        .JOB_W (JOB_W)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .trigger_i     (trigger_i),
        .clear_i       (clear_i),
        .cfg_len_i     (cfg_len_i),
        .cfg_timeout_i (cfg_timeout_i),
        .eng           (eng_if),
        .busy_o        (busy_o),
        .evt_done_o    (evt_done_o),
        .evt_err_o     (evt_err_o),
        .status_o      (status_o),
        .jobs_o        (jobs_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_jobs = 0;
    int exp_status = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int ph);
        check({tag, ".eng_clear"}, eng_if.eng_clear_o, ph == PH_CLR);
        check({tag, ".eng_start"}, eng_if.eng_start_o, ph == PH_START);
        check({tag, ".evt_done"},  evt_done_o,         ph == PH_DONE);
        check({tag, ".evt_err"},   evt_err_o,          ph == PH_ERR);
        check({tag, ".busy"},      busy_o,             ph != PH_IDLE);
    endtask

    task automatic check_idle_state(input string tag);
        check_outs(tag, PH_IDLE);
        check({tag, ".status"}, status_o, exp_status);
        check({tag, ".jobs"},   jobs_o,   exp_jobs);
    endtask

    // One job. d = first WAIT_READY cycle (0-based) with the engine ready,
    // k = first RUN cycle (0-based) in which the count reaches the length.
    task automatic run_job(input string name, input int len, input int tmo,
                           input int d, input int k);
        bit    zero, tw, tr;
        int    w, r, ce, ph;
        string tag;
        zero = (len == 0);
        tw   = !zero && (tmo != 0) && (d >= tmo);
        w    = tw ? tmo : d + 1;
        tr   = !zero && !tw && (tmo != 0) && (k >= tmo);
        r    = tr ? tmo : k + 1;
        if (zero)    ce = 1;
        else if (tw) ce = 2 + tmo;
        else         ce = 3 + w + r;

        @(negedge clk);
        cfg_len_i          = CNT_W'(len);
        cfg_timeout_i      = CNT_W'(tmo);
        trigger_i          = 1'b1;
        eng_if.eng_ready_i = 1'b0;
        eng_if.eng_cnt_i   = '0;

        for (int c = 1; c <= ce + 1; c++) begin
            @(posedge clk);
            #1;
            tag = $sformatf("%s.c%0d", name, c);
            if (c == ce + 1)      ph = PH_IDLE;
            else if (zero)        ph = PH_ERR;
            else if (c == 1)      ph = PH_CLR;
            else if (c <= 1 + w)  ph = PH_WAIT;
            else if (tw)          ph = PH_ERR;
            else if (c == 2 + w)  ph = PH_START;
            else if (c <= 2 + w + r) ph = PH_RUN;
            else                  ph = tr ? PH_ERR : PH_DONE;
            check_outs(tag, ph);

            if (c == 1 && !zero) check({tag, ".status"}, status_o, 0);
            if (c == ce) begin
                if (ph == PH_DONE) begin
                    exp_jobs   = (exp_jobs + 1) % JOB_MOD;
                    exp_status = 1;
                end else begin
                    exp_status = zero ? 3 : 2;
                end
                check({tag, ".status"}, status_o, exp_status);
                check({tag, ".jobs"},   jobs_o,   exp_jobs);
            end
            if (c == ce + 1) begin
                check({tag, ".status"}, status_o, exp_status);
                check({tag, ".jobs"},   jobs_o,   exp_jobs);
            end

            // Stray triggers with a different length must be ignored mid-job.
            trigger_i          = (c < ce + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_len_i          = CNT_W'($urandom_range(0, 300));
            eng_if.eng_ready_i = (c >= 2 + d);
            if (!zero && !tw && !tr && c >= 3 + w + k)
                eng_if.eng_cnt_i = CNT_W'(len + $urandom_range(0, 3));
            else
                eng_if.eng_cnt_i = (len > 0) ? CNT_W'($urandom_range(0, len - 1)) : '0;
        end
        trigger_i          = 1'b0;
        eng_if.eng_ready_i = 1'b0;
        eng_if.eng_cnt_i   = '0;
    endtask

    initial begin
        eng_if.eng_ready_i = 1'b0;
        eng_if.eng_cnt_i   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_idle_state("reset");
        rst_ni = 1'b1;

        // Nominal, zero length, RUN timeout.
        run_job("nominal", 4, 0, 0, 4);
        run_job("zerolen", 0, 0, 0, 0);
        run_job("timeout", 8, 10, 0, 20);
        run_job("wait_tmo", 5, 3, 7, 0);

        // Three more successful jobs: the 2-bit counter wraps to 0.
        run_job("wrap1", 3, 0, 1, 2);
        run_job("wrap2", 2, 0, 0, 0);
        run_job("wrap3", 6, 0, 2, 3);
        @(negedge clk);
        check("wrap.jobs", jobs_o, 0);

        // Ready rises in the same cycle the wait budget expires: START wins.
        run_job("race_wait", 6, 5, 4, 1);
        // Count condition in the last RUN cycle of the budget: DONE wins.
        run_job("race_run", 3, 4, 0, 3);

        // Abort in RUN with a simultaneous trigger.
        @(negedge clk);
        cfg_len_i = 8; cfg_timeout_i = 0; trigger_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            trigger_i          = 1'b0;
            eng_if.eng_ready_i = 1'b1;
            eng_if.eng_cnt_i   = 2;
        end
        check("abort.run.busy", busy_o, 1);
        clear_i = 1'b1; trigger_i = 1'b1; cfg_len_i = 5;
        @(posedge clk);
        #1;
        clear_i = 1'b0; trigger_i = 1'b0; eng_if.eng_ready_i = 1'b0;
        exp_status = 0;
        check("abort.c1.eng_clear", eng_if.eng_clear_o, 1);
        check("abort.c1.eng_start", eng_if.eng_start_o, 0);
        check("abort.c1.evt_done",  evt_done_o, 0);
        check("abort.c1.evt_err",   evt_err_o, 0);
        check("abort.c1.busy",      busy_o, 0);
        check("abort.c1.status",    status_o, 0);
        check("abort.c1.jobs",      jobs_o, exp_jobs);
        @(posedge clk);
        #1;
        check_idle_state("abort.c2");

        // Randomised jobs.
        for (int j = 0; j < 24; j++) begin
            int len, tmo, d, k;
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            d   = $urandom_range(0, 14);
            k   = $urandom_range(0, 14);
            run_job($sformatf("rnd%0d", j), len, tmo, d, k);
        end

        // Reset in WAIT_READY: outputs clear without waiting for a clock.
        @(negedge clk);
        cfg_len_i = 8; cfg_timeout_i = 0; trigger_i = 1'b1;
        @(posedge clk); #1; trigger_i = 1'b0;
        @(posedge clk); #1;
        check("rstmid.busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        exp_jobs = 0; exp_status = 0;
        check_idle_state("rstmid");
        @(negedge clk);
        rst_ni = 1'b1;
        run_job("after_rst", 3, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so a stuck run still ends.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
